// File: rtl/digit_buf_pkg.sv
// Shared constants, types and helpers for the digit-entry buffer.
package digit_buf_pkg;

  localparam int DIG_W_DEF = 4;
  localparam int N_DIG_DEF = 4;

  typedef enum logic {
    OVF_DROP   = 1'b0,
    OVF_REJECT = 1'b1
  } ovf_mode_e;

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/entry_idle_timer.sv
// Idle timer for the digit-entry buffer: pulses expire on the edge that
// completes TIMEOUT_CYC idle cycles while armed.
module entry_idle_timer #(
  parameter int TIMEOUT_CYC = 50_000_000
) (
  input  logic clk,
  input  logic nrst,
  input  logic activity,
  input  logic armed,
  output logic expire
);

  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYC - 1);

  logic [TW-1:0] remain_q;

  // Down-counter reloads on any activity or while disarmed; terminal count 0.
  assign expire = armed & ~activity & (remain_q == '0);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      remain_q <= LAST;
    end else if (!armed || activity || expire) begin
      remain_q <= LAST;
    end else begin
      remain_q <= remain_q - TW'(1);
    end
  end

endmodule

// File: rtl/digit_entry_buf.sv
// Keypad digit-entry shift buffer with backspace, clear and overflow policy.
// Optional auto-clear on idle is enabled by defining ENTRY_TIMEOUT_EN.
import digit_buf_pkg::*;

module digit_entry_buf #(
  parameter int N_DIG       = N_DIG_DEF,
  parameter int DIG_W       = DIG_W_DEF,
  parameter int OVF_MODE    = 0,
  parameter int TIMEOUT_CYC = 50_000_000
) (
  input  logic                        clk,
  input  logic                        nrst,
  input  logic                        push,
  input  logic [DIG_W-1:0]            din,
  input  logic                        bksp,
  input  logic                        clr,
  output logic [N_DIG*DIG_W-1:0]      digits,
  output logic [N_DIG-1:0]            valid,
  output logic [cnt_w(N_DIG)-1:0]     count,
  output logic                        full,
  output logic                        ovf,
  output logic                        timeout
);

  localparam int CW = cnt_w(N_DIG);
  localparam logic [CW-1:0] FULL_CNT = CW'(N_DIG);
  localparam ovf_mode_e MODE = ovf_mode_e'(OVF_MODE[0]);

  logic [DIG_W-1:0] slot_q [N_DIG];
  logic [DIG_W-1:0] slot_d [N_DIG];
  logic [N_DIG-1:0] valid_q, valid_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             timeout_q;
  logic             expire;
  logic             is_full, is_empty;

  assign is_full  = (count_q == FULL_CNT);
  assign is_empty = (count_q == '0);

`ifdef ENTRY_TIMEOUT_EN
  logic activity;
  assign activity = push | bksp | clr;

  entry_idle_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_idle_timer (
    .clk      (clk),
    .nrst     (nrst),
    .activity (activity),
    .armed    (~is_empty),
    .expire   (expire)
  );
`else
  assign expire = 1'b0;
`endif

  always_comb begin
    slot_d  = slot_q;
    valid_d = valid_q;
    count_d = count_q;
    ovf_d   = 1'b0;

    if (clr || expire) begin
      for (int i = 0; i < N_DIG; i++) slot_d[i] = '0;
      valid_d = '0;
      count_d = '0;
    end else if (push && bksp && !is_empty) begin
      slot_d[0] = din;
    end else if (push) begin
      // Full: drop-oldest shifts anyway, reject leaves state alone.
      if (!is_full || MODE == OVF_DROP) begin
        for (int i = N_DIG - 1; i > 0; i--) slot_d[i] = slot_q[i-1];
        slot_d[0] = din;
        valid_d   = {valid_q[N_DIG-2:0], 1'b1};
      end
      if (is_full) ovf_d = 1'b1;
      else         count_d = count_q + CW'(1);
    end else if (bksp && !is_empty) begin
      for (int i = 0; i < N_DIG - 1; i++) slot_d[i] = slot_q[i+1];
      slot_d[N_DIG-1] = '0;
      valid_d = {1'b0, valid_q[N_DIG-1:1]};
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < N_DIG; i++) slot_q[i] <= '0;
      valid_q   <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      slot_q    <= slot_d;
      valid_q   <= valid_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      timeout_q <= expire;
    end
  end

  always_comb begin
    digits = '0;
    for (int i = 0; i < N_DIG; i++) digits[i*DIG_W +: DIG_W] = slot_q[i];
  end

  assign valid   = valid_q;
  assign count   = count_q;
  assign full    = is_full;
  assign ovf     = ovf_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_digit_entry_buf.sv
// Scoreboard bench for digit_entry_buf: drop-oldest and reject instances
// share stimulus and are checked against a queue-based reference model.
module tb_digit_entry_buf;

  typedef logic [3:0] dq_t[$];

  typedef struct packed {
    logic [15:0] d;
    logic [3:0]  v;
    logic [2:0]  c;
    logic        f;
    logic        o;
    logic        t;
  } exp_t;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        push = 1'b0, bksp = 1'b0, clr = 1'b0;
  logic [3:0]  din = '0;

  logic [15:0] digits0, digits1;
  logic [3:0]  valid0, valid1;
  logic [2:0]  count0, count1;
  logic        full0, full1, ovf0, ovf1, to0, to1;

  int   n_checks = 0;
  int   n_fail = 0;
  int   ic = 0;
  dq_t  q0, q1;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  digit_entry_buf #(.N_DIG(4), .DIG_W(4), .OVF_MODE(0), .TIMEOUT_CYC(10)) dut0 (
    .clk(clk), .nrst(nrst), .push(push), .din(din), .bksp(bksp), .clr(clr),
    .digits(digits0), .valid(valid0), .count(count0), .full(full0),
    .ovf(ovf0), .timeout(to0));

  digit_entry_buf #(.N_DIG(4), .DIG_W(4), .OVF_MODE(1), .TIMEOUT_CYC(10)) dut1 (
    .clk(clk), .nrst(nrst), .push(push), .din(din), .bksp(bksp), .clr(clr),
    .digits(digits1), .valid(valid1), .count(count1), .full(full1),
    .ovf(ovf1), .timeout(to1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic dq_t apply(input dq_t q, input int mode, input bit p, input bit b,
                                input bit c, input logic [3:0] d, output bit ov);
    logic [3:0] tmp;
    ov = 1'b0;
    if (c) begin
      q.delete();
    end else if (p && b && q.size() > 0) begin
      q[0] = d;
    end else if (p) begin
      if (q.size() < 4) begin
        q.push_front(d);
      end else begin
        ov = 1'b1;
        if (mode == 0) begin
          q.push_front(d);
          tmp = q.pop_back();
        end
      end
    end else if (b && q.size() > 0) begin
      tmp = q.pop_front();
    end
    return q;
  endfunction

  function automatic exp_t mk(input dq_t q, input bit ov, input bit ex);
    exp_t e;
    e = '0;
    for (int i = 0; i < q.size(); i++) e.d[i*4 +: 4] = q[i];
    e.c = 3'(q.size());
    e.v = 4'((1 << q.size()) - 1);
    e.f = (q.size() == 4);
    e.o = ov;
    e.t = ex;
    return e;
  endfunction

  task automatic cmp(input string who, input exp_t e, input logic [15:0] d, input logic [3:0] v,
                     input logic [2:0] c, input logic f, input logic o, input logic t);
    chk({who, "_digits"}, 32'(d), 32'(e.d));
    chk({who, "_valid"},  32'(v), 32'(e.v));
    chk({who, "_count"},  32'(c), 32'(e.c));
    chk({who, "_full"},   32'(f), 32'(e.f));
    chk({who, "_ovf"},    32'(o), 32'(e.o));
    chk({who, "_timeout"},32'(t), 32'(e.t));
  endtask

  task automatic cyc(input bit p, input bit b, input bit c, input logic [3:0] d);
    bit   ov0, ov1, ex;
    exp_t e0, e1;
    @(negedge clk);
    push = p; bksp = b; clr = c; din = d;
    ex = 1'b0;
`ifdef ENTRY_TIMEOUT_EN
    if (q0.size() > 0 && !(p | b | c) && ic == 9) ex = 1'b1;
    if (ex || q0.size() == 0 || p || b || c) ic = 0;
    else ic++;
`endif
    q0 = apply(q0, 0, p, b, c | ex, d, ov0);
    q1 = apply(q1, 1, p, b, c | ex, d, ov1);
    exp_q.push_back(mk(q0, ov0, ex));
    exp_q.push_back(mk(q1, ov1, ex));
    @(posedge clk);
    #1;
    push = 1'b0; bksp = 1'b0; clr = 1'b0;
    chk("sb_depth", 32'(exp_q.size()), 32'd2);
    if (exp_q.size() >= 2) begin
      e0 = exp_q.pop_front();
      e1 = exp_q.pop_front();
      cmp("drop", e0, digits0, valid0, count0, full0, ovf0, to0);
      cmp("rej",  e1, digits1, valid1, count1, full1, ovf1, to1);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_d0"}, 32'({digits0, valid0, count0, full0, ovf0, to0}), 32'd0);
    chk({tag, "_d1"}, 32'({digits1, valid1, count1, full1, ovf1, to1}), 32'd0);
  endtask

  initial begin
    #2;
    chk_zero("reset");
    @(negedge clk);
    nrst = 1'b1;

    // 1: push 1,2,3
    cyc(1, 0, 0, 4'd1); cyc(1, 0, 0, 4'd2); cyc(1, 0, 0, 4'd3);
    chk("t1_digits", 32'(digits0), 32'h0123);
    chk("t1_valid", 32'(valid0), 32'b0111);

    // 2: overflow policy
    cyc(0, 0, 1, 4'd0);
    for (int i = 1; i <= 5; i++) cyc(1, 0, 0, 4'(i));
    chk("t2_drop_digits", 32'(digits0), 32'h2345);
    chk("t2_rej_digits", 32'(digits1), 32'h1234);
    cyc(0, 0, 0, 4'd0);

    // 3: backspace down to empty and beyond
    cyc(0, 0, 1, 4'd0);
    cyc(1, 0, 0, 4'd7); cyc(1, 0, 0, 4'd8); cyc(1, 0, 0, 4'd9);
    cyc(0, 1, 0, 4'd0); cyc(0, 1, 0, 4'd0);
    chk("t3_digits", 32'(digits0), 32'h0007);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 4'd0);
    chk("t3_count", 32'(count0), 32'd0);

    // 4: replace newest, clear beats push
    cyc(1, 0, 0, 4'd6); cyc(1, 0, 0, 4'd5);
    cyc(1, 1, 0, 4'd9);
    chk("t4_replace", 32'(digits0), 32'h0069);
    cyc(1, 0, 1, 4'd3);
    cyc(1, 1, 0, 4'hA);

    // 5: asynchronous reset mid-cycle
    cyc(1, 0, 0, 4'd2); cyc(1, 0, 0, 4'd8);
    #2;
    nrst = 1'b0;
    #1;
    chk_zero("async_rst");
    q0.delete(); q1.delete(); ic = 0;
    @(negedge clk);
    nrst = 1'b1;
    cyc(1, 0, 0, 4'hF);
    chk("t5_count", 32'(count0), 32'd1);

    // random mix with a bias toward pushes
    for (int i = 0; i < 300; i++) begin
      int r;
      r = $urandom_range(0, 99);
      cyc(r < 45, (r >= 35 && r < 70), (r >= 96), 4'($urandom));
    end

`ifdef ENTRY_TIMEOUT_EN
    // 6: idle auto-clear and last-moment push
    cyc(0, 0, 1, 4'd0);
    cyc(1, 0, 0, 4'd4);
    for (int i = 0; i < 12; i++) cyc(0, 0, 0, 4'd0);
    chk("t6_cleared", 32'(count0), 32'd0);
    cyc(1, 0, 0, 4'd4);
    for (int i = 0; i < 9; i++) cyc(0, 0, 0, 4'd0);
    cyc(1, 0, 0, 4'd5);
    chk("t6_kept", 32'(count0), 32'd2);
    for (int i = 0; i < 12; i++) cyc(0, 0, 0, 4'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
